// File: rtl/t04_writeback_unit.sv
// Writeback stage of the team_04 RV32I core: selects the rd result and runs
// multi-cycle loads through a request/ack handshake with a timeout.
module t04_writeback_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [1:0]  wb_src,
   input  logic        reg_write_in,
   input  logic [4:0]  rd,
   input  logic [31:0] alu_result,
   input  logic [31:0] pc_plus4,
   input  logic [31:0] imm,
   input  logic [1:0]  load_size,
   input  logic        load_unsigned,
   output logic        mem_read_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        misalign_err,
   output logic        timeout_err
);

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_WAIT_MEM = 1'b1;

   localparam logic [1:0] SRC_ALU  = 2'b00;
   localparam logic [1:0] SRC_LOAD = 2'b01;
   localparam logic [1:0] SRC_PC4  = 2'b10;
   localparam logic [1:0] SRC_IMM  = 2'b11;

   // The counter holds completed WAIT_MEM cycles, so the limit is hit one below.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [0:0]  state_r;
   logic [7:0]  cnt_r;
   logic        ld_we_r;
   logic [4:0]  ld_rd_r;
   logic [1:0]  ld_size_r;
   logic        ld_uns_r;
   logic [1:0]  ld_off_r;

   logic        accept_s;
   logic        misalign_s;
   logic        timeout_hit_s;
   logic [31:0] sel_data_s;

   // Byte/half lane extraction with sign or zero extension; words pass through.
   function automatic logic [31:0] extract_load(
      input logic [31:0] rdata,
      input logic [1:0]  size,
      input logic        uns,
      input logic [1:0]  off
   );
      logic [31:0] shifted;
      logic [15:0] half;
      logic [31:0] res;
      shifted = rdata >> {off, 3'b000};
      half    = off[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         2'b00:   res = {{24{shifted[7] & ~uns}}, shifted[7:0]};
         2'b01:   res = {{16{half[15] & ~uns}}, half};
         default: res = rdata;
      endcase
      return res;
   endfunction

   assign wb_ready = (state_r == ST_IDLE);

   // Acceptance, result selection, alignment check and timeout detection.
   always_comb begin
      accept_s      = wb_valid && (state_r == ST_IDLE);
      timeout_hit_s = (cnt_r == TIMEOUT_LAST);
      case (wb_src)
         SRC_ALU:  sel_data_s = alu_result;
         SRC_PC4:  sel_data_s = pc_plus4;
         SRC_IMM:  sel_data_s = imm;
         default:  sel_data_s = alu_result;
      endcase
      case (load_size)
         2'b00:   misalign_s = 1'b0;
         2'b01:   misalign_s = alu_result[0];
         default: misalign_s = (alu_result[1:0] != 2'b00);
      endcase
   end

   // Writeback FSM with registered request, strobe and error outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 8'd0;
         mem_read_req <= 1'b0;
         mem_addr     <= 32'd0;
         rf_we        <= 1'b0;
         rf_waddr     <= 5'd0;
         rf_wdata     <= 32'd0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
         ld_we_r      <= 1'b0;
         ld_rd_r      <= 5'd0;
         ld_size_r    <= 2'b00;
         ld_uns_r     <= 1'b0;
         ld_off_r     <= 2'b00;
      end else begin
         rf_we        <= 1'b0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s && (wb_src == SRC_LOAD)) begin
                  if (misalign_s) begin
                     misalign_err <= 1'b1;
                  end else begin
                     ld_we_r      <= reg_write_in;
                     ld_rd_r      <= rd;
                     ld_size_r    <= load_size;
                     ld_uns_r     <= load_unsigned;
                     ld_off_r     <= alu_result[1:0];
                     mem_addr     <= {alu_result[31:2], 2'b00};
                     cnt_r        <= 8'd0;
                     mem_read_req <= 1'b1;
                     state_r      <= ST_WAIT_MEM;
                  end
               end else if (accept_s) begin
                  rf_we    <= reg_write_in && (rd != 5'd0);
                  rf_waddr <= rd;
                  rf_wdata <= sel_data_s;
               end
            end
            ST_WAIT_MEM: begin
               // An ack on the final allowed cycle still commits.
               if (mem_ack) begin
                  rf_we        <= ld_we_r && (ld_rd_r != 5'd0);
                  rf_waddr     <= ld_rd_r;
                  rf_wdata     <= extract_load(mem_rdata, ld_size_r, ld_uns_r, ld_off_r);
                  mem_read_req <= 1'b0;
                  state_r      <= ST_IDLE;
               end else if (timeout_hit_s) begin
                  timeout_err  <= 1'b1;
                  mem_read_req <= 1'b0;
                  state_r      <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            default: begin
               mem_read_req <= 1'b0;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_t04_writeback_unit.sv
// Self-checking bench for t04_writeback_unit: directed table, hand-written
// reset/idle-ack sequences and randomized transactions against a reference model.
module tb_t04_writeback_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic        wb_ready;
   logic [1:0]  wb_src;
   logic        reg_write_in;
   logic [4:0]  rd;
   logic [31:0] alu_result;
   logic [31:0] pc_plus4;
   logic [31:0] imm;
   logic [1:0]  load_size;
   logic        load_unsigned;
   logic        mem_read_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        misalign_err;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   t04_writeback_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_src(wb_src), .reg_write_in(reg_write_in), .rd(rd),
      .alu_result(alu_result), .pc_plus4(pc_plus4), .imm(imm),
      .load_size(load_size), .load_unsigned(load_unsigned),
      .mem_read_req(mem_read_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .misalign_err(misalign_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  src;
      logic        rwe;
      logic [4:0]  rdn;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [31:0] immv;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] rdata;
      int          ack_dly;
      logic        exp_we;
      logic [31:0] exp_wdata;
      logic        exp_mis;
      logic        exp_to;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] src, input logic rwe, input logic [4:0] rdn,
                               input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] immv,
                               input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                               input int ack_dly, input logic exp_we, input logic [31:0] exp_wdata,
                               input logic exp_mis, input logic exp_to);
      vec_t v;
      v.src = src; v.rwe = rwe; v.rdn = rdn; v.alu = alu; v.pc4 = pc4; v.immv = immv;
      v.size = size; v.uns = uns; v.rdata = rdata; v.ack_dly = ack_dly;
      v.exp_we = exp_we; v.exp_wdata = exp_wdata; v.exp_mis = exp_mis; v.exp_to = exp_to;
      return v;
   endfunction

   // Reference model: derives expected results from the architectural rules.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int unsigned off;
      logic [31:0] raw;
      logic is_load;
      r = v;
      off = int'(v.alu[1:0]);
      is_load = (v.src == 2'd1);
      r.exp_mis = is_load && ((v.size == 2'd1) ? (off % 2 != 0) : (v.size != 2'd0 && off != 0));
      r.exp_to  = is_load && !r.exp_mis && (v.ack_dly > TO);
      if (!is_load) begin
         r.exp_wdata = (v.src == 2'd0) ? v.alu : (v.src == 2'd2) ? v.pc4 : v.immv;
      end else if (v.size == 2'd0) begin
         raw = (v.rdata >> (8 * off)) & 32'h0000_00FF;
         r.exp_wdata = v.uns ? raw : (raw ^ 32'h0000_0080) - 32'h0000_0080;
      end else if (v.size == 2'd1) begin
         raw = (v.rdata >> (16 * (off / 2))) & 32'h0000_FFFF;
         r.exp_wdata = v.uns ? raw : (raw ^ 32'h0000_8000) - 32'h0000_8000;
      end else begin
         r.exp_wdata = v.rdata;
      end
      r.exp_we = v.rwe && (v.rdn != 5'd0) && !r.exp_mis && !r.exp_to;
      return r;
   endfunction

   task automatic run_txn(input vec_t v);
      int k;
      bit done;
      wb_valid = 1'b1; wb_src = v.src; reg_write_in = v.rwe; rd = v.rdn;
      alu_result = v.alu; pc_plus4 = v.pc4; imm = v.immv;
      load_size = v.size; load_unsigned = v.uns;
      @(posedge clk); #1;
      wb_valid = 1'b0;
      if (v.src == 2'd1 && !v.exp_mis) begin
         chk("mem_addr", mem_addr, {v.alu[31:2], 2'b00});
         k = 1; done = 1'b0;
         while (!done) begin
            chk("wait_req", {31'd0, mem_read_req}, 32'd1);
            chk("wait_ready", {31'd0, wb_ready}, 32'd0);
            if (k == v.ack_dly) begin
               mem_ack = 1'b1; mem_rdata = v.rdata; done = 1'b1;
            end else if (k >= TO) begin
               done = 1'b1;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
            k++;
         end
      end
      chk("req_after", {31'd0, mem_read_req}, 32'd0);
      chk("rf_we", {31'd0, rf_we}, {31'd0, v.exp_we});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, v.exp_mis});
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, v.exp_to});
      chk("ready_after", {31'd0, wb_ready}, 32'd1);
      if (v.exp_we) begin
         chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, v.rdn});
         chk("rf_wdata", rf_wdata, v.exp_wdata);
      end
   endtask

   initial begin
      vec_t v;
      tbl[0]  = mk(2'd0, 1'b1, 5'd5, 32'h0000_002A, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 0, 1'b1, 32'h0000_002A, 1'b0, 1'b0);
      tbl[1]  = mk(2'd2, 1'b1, 5'd1, 32'h0000_0055, 32'h0000_0104, 32'h0, 2'd0, 1'b0, 32'h0, 0, 1'b1, 32'h0000_0104, 1'b0, 1'b0);
      tbl[2]  = mk(2'd3, 1'b1, 5'd7, 32'h0, 32'h0, 32'h1234_5000, 2'd0, 1'b0, 32'h0, 0, 1'b1, 32'h1234_5000, 1'b0, 1'b0);
      tbl[3]  = mk(2'd0, 1'b0, 5'd3, 32'h0000_0011, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
      tbl[4]  = mk(2'd0, 1'b1, 5'd0, 32'h0000_0022, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
      tbl[5]  = mk(2'd1, 1'b1, 5'd8, 32'h0000_1003, 32'h0, 32'h0, 2'd0, 1'b0, 32'h80FF_1234, 3, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
      tbl[6]  = mk(2'd1, 1'b1, 5'd9, 32'h0000_2002, 32'h0, 32'h0, 2'd1, 1'b1, 32'hBEEF_0000, 1, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0);
      tbl[7]  = mk(2'd1, 1'b1, 5'd10, 32'h0000_3001, 32'h0, 32'h0, 2'd2, 1'b0, 32'h0, 1, 1'b0, 32'h0, 1'b1, 1'b0);
      tbl[8]  = mk(2'd1, 1'b1, 5'd11, 32'h0000_4000, 32'h0, 32'h0, 2'd2, 1'b0, 32'h1111_2222, 9, 1'b0, 32'h0, 1'b0, 1'b1);
      tbl[9]  = mk(2'd1, 1'b1, 5'd12, 32'h0000_4004, 32'h0, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 4, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      tbl[10] = mk(2'd1, 1'b1, 5'd0, 32'h0000_4008, 32'h0, 32'h0, 2'd2, 1'b0, 32'hCAFE_0001, 2, 1'b0, 32'h0, 1'b0, 1'b0);
      tbl[11] = mk(2'd1, 1'b1, 5'd13, 32'h0000_0010, 32'h0, 32'h0, 2'd1, 1'b0, 32'h0000_8001, 1, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0);
      tbl[12] = mk(2'd1, 1'b1, 5'd14, 32'h0000_0011, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0000_A500, 2, 1'b1, 32'h0000_00A5, 1'b0, 1'b0);
      tbl[13] = mk(2'd1, 1'b1, 5'd15, 32'h0000_0022, 32'h0, 32'h0, 2'd3, 1'b0, 32'h0, 1, 1'b0, 32'h0, 1'b1, 1'b0);
      tbl[14] = mk(2'd1, 1'b1, 5'd16, 32'h0000_0020, 32'h0, 32'h0, 2'd3, 1'b1, 32'h8765_4321, 1, 1'b1, 32'h8765_4321, 1'b0, 1'b0);
      tbl[15] = mk(2'd1, 1'b1, 5'd17, 32'h0000_2001, 32'h0, 32'h0, 2'd1, 1'b0, 32'h0, 1, 1'b0, 32'h0, 1'b1, 1'b0);

      rst = 1'b1; wb_valid = 1'b0; wb_src = 2'd0; reg_write_in = 1'b0; rd = 5'd0;
      alu_result = 32'd0; pc_plus4 = 32'd0; imm = 32'd0; load_size = 2'd0;
      load_unsigned = 1'b0; mem_rdata = 32'd0; mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, wb_ready}, 32'd1);
      chk("rst_req", {31'd0, mem_read_req}, 32'd0);
      chk("rst_we", {31'd0, rf_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
      rst = 1'b0;

      // Directed table; entries 0 and 1 run back to back.
      for (int i = 0; i < 16; i++) run_txn(tbl[i]);

      // Ack while idle must not write.
      mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("idle_ack_we", {31'd0, rf_we}, 32'd0);
      chk("idle_ack_ready", {31'd0, wb_ready}, 32'd1);

      // Reset in the second WAIT_MEM cycle drops the request; a late ack is ignored.
      wb_valid = 1'b1; wb_src = 2'd1; reg_write_in = 1'b1; rd = 5'd9;
      alu_result = 32'h0000_5000; load_size = 2'd2;
      @(posedge clk); #1;
      wb_valid = 1'b0;
      chk("rstw_req1", {31'd0, mem_read_req}, 32'd1);
      @(posedge clk); #1;
      chk("rstw_req2", {31'd0, mem_read_req}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstw_req_drop", {31'd0, mem_read_req}, 32'd0);
      chk("rstw_ready", {31'd0, wb_ready}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("rstw_late_ack_we", {31'd0, rf_we}, 32'd0);
      chk("rstw_ready2", {31'd0, wb_ready}, 32'd1);

      // Randomized transactions against the reference model.
      for (int n = 0; n < 300; n++) begin
         v.src = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) v.src = 2'd1;
         v.rwe = ($urandom_range(0, 7) != 0);
         v.rdn = 5'($urandom_range(0, 31));
         v.alu = $urandom; v.pc4 = $urandom; v.immv = $urandom;
         if ($urandom_range(0, 1) == 1) v.alu[1:0] = 2'b00;
         v.size = 2'($urandom_range(0, 3));
         v.uns = 1'($urandom_range(0, 1));
         v.rdata = $urandom;
         v.ack_dly = $urandom_range(1, TO + 2);
         run_txn(model(v));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
